// File: rtl/mem_pkg.sv
// Shared widths, FSM and grant encodings for the line-memory arbiter.
package mem_pkg;

    localparam int unsigned LINE_W  = 128;
    localparam int unsigned LADDR_W = 28;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

    // On a collision the side that lost the previous grant wins.
    function automatic grant_e pick_grant(input logic req_i, input logic req_d, input grant_e last);
        if (req_i && req_d) begin
            return (last == GNT_I) ? GNT_D : GNT_I;
        end
        return req_d ? GNT_D : GNT_I;
    endfunction

endpackage

// File: rtl/mem_line_ram.sv
// Single-port line store: synchronous write, combinational read of the same index.
module mem_line_ram
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_LINES = 256,
    parameter int unsigned IDX_W       = $clog2(DEPTH_LINES)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata_c
);

    logic [LINE_W-1:0] mem [DEPTH_LINES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata_c = mem[addr];

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (I/D) line memory with fixed response latency and alternating
// arbitration; one transaction in flight at a time.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned LATENCY     = 5,
    parameter int unsigned DEPTH_LINES = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               reqI_mem,
    input  logic [LADDR_W-1:0] reqAddrI_mem,
    output logic [LINE_W-1:0]  data_to_icache,
    output logic               ready_I,
    input  logic               reqD_mem,
    input  logic               reqD_write,
    input  logic [LADDR_W-1:0] reqAddrD_mem,
    input  logic [LINE_W-1:0]  reqD_wdata,
    output logic [LINE_W-1:0]  data_to_dcache,
    output logic               ready_D,
    output logic               written_ack_D,
    output logic               busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH_LINES);

    state_e             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    grant_e             side, side_nxt;
    grant_e             last_grant, last_nxt;
    grant_e             gnt_c;
    logic               is_wr, wr_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [LINE_W-1:0]  wdata, wdata_nxt;
    logic               ready_i_nxt, ready_d_nxt, ack_nxt;
    logic               ram_we_c;
    logic [LINE_W-1:0]  ram_rdata_c;

    // Upper line-address bits are deliberately dropped so addresses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{reqAddrI_mem[LADDR_W-1:IDX_W], reqAddrD_mem[LADDR_W-1:IDX_W]};

    mem_line_ram #(
        .DEPTH_LINES (DEPTH_LINES),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we_c),
        .addr    (idx),
        .wdata   (wdata),
        .rdata_c (ram_rdata_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            side          <= GNT_I;
            last_grant    <= GNT_I;
            is_wr         <= 1'b0;
            idx           <= '0;
            wdata         <= '0;
            ready_I       <= 1'b0;
            ready_D       <= 1'b0;
            written_ack_D <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            side          <= side_nxt;
            last_grant    <= last_nxt;
            is_wr         <= wr_nxt;
            idx           <= idx_nxt;
            wdata         <= wdata_nxt;
            ready_I       <= ready_i_nxt;
            ready_D       <= ready_d_nxt;
            written_ack_D <= ack_nxt;
            busy          <= (state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        side_nxt    = side;
        last_nxt    = last_grant;
        wr_nxt      = is_wr;
        idx_nxt     = idx;
        wdata_nxt   = wdata;
        ready_i_nxt = 1'b0;
        ready_d_nxt = 1'b0;
        ack_nxt     = 1'b0;
        ram_we_c    = 1'b0;
        gnt_c       = pick_grant(reqI_mem, reqD_mem, last_grant);

        unique case (state)
            ST_IDLE: begin
                if (reqI_mem || reqD_mem) begin
                    side_nxt  = gnt_c;
                    last_nxt  = gnt_c;
                    cnt_nxt   = CNT_W'(LATENCY - 1);
                    state_nxt = ST_WAIT;
                    if (gnt_c == GNT_D) begin
                        wr_nxt    = reqD_write;
                        idx_nxt   = reqAddrD_mem[IDX_W-1:0];
                        wdata_nxt = reqD_wdata;
                    end else begin
                        wr_nxt    = 1'b0;
                        idx_nxt   = reqAddrI_mem[IDX_W-1:0];
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = ST_RESPOND;
                    // Write commits on the same edge that enters RESPOND.
                    if (is_wr) begin
                        ram_we_c = 1'b1;
                        ack_nxt  = 1'b1;
                    end else if (side == GNT_I) begin
                        ready_i_nxt = 1'b1;
                    end else begin
                        ready_d_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_RESPOND: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Read lines land in the side's holding register with the ready pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_to_icache <= '0;
            data_to_dcache <= '0;
        end else begin
            if (ready_i_nxt) begin
                data_to_icache <= ram_rdata_c;
            end
            if (ready_d_nxt) begin
                data_to_dcache <= ram_rdata_c;
            end
        end
    end

endmodule
